// File: rtl/tile_fetch_if.sv
// Tile fetch bus: start request, padded map input, tile stream with valid/ready and status.
// tile_sum exists only when TILE_FETCH_SUM_EN is defined.
interface tile_fetch_if #(
  parameter int unsigned SIZE        = 7,
  parameter int unsigned FILTER_SIZE = 3
);
  localparam int unsigned OUT_SIZE = SIZE + ((FILTER_SIZE - (SIZE % FILTER_SIZE)) % FILTER_SIZE);

  logic        en;
  logic [31:0] array_in [0:OUT_SIZE-1][0:OUT_SIZE-1];
  logic [31:0] tile_out [0:FILTER_SIZE-1][0:FILTER_SIZE-1];
  logic        tile_valid;
  logic        tile_ready;
  logic [7:0]  tile_row;
  logic [7:0]  tile_col;
  logic        tile_last;
  logic        busy;
  logic        done;
`ifdef TILE_FETCH_SUM_EN
  logic [31:0] tile_sum;
`endif

  modport master (
    input  en, array_in, tile_ready,
    output tile_out, tile_valid, tile_row, tile_col, tile_last, busy, done
`ifdef TILE_FETCH_SUM_EN
    , tile_sum
`endif
  );

  modport slave (
    output en, array_in, tile_ready,
    input  tile_out, tile_valid, tile_row, tile_col, tile_last, busy, done
`ifdef TILE_FETCH_SUM_EN
    , tile_sum
`endif
  );
endinterface

// File: rtl/tile_fetch.sv
// Captures a padded feature map and streams it as FILTER_SIZE x FILTER_SIZE tiles in row-major order.
// Optional per-tile element sum output enabled by macro TILE_FETCH_SUM_EN.
module tile_fetch #(
  parameter int unsigned SIZE        = 7,
  parameter int unsigned FILTER_SIZE = 3
) (
  input logic         clk,
  input logic         reset,
  tile_fetch_if.master bus
);
  localparam int unsigned OUT_SIZE = SIZE + ((FILTER_SIZE - (SIZE % FILTER_SIZE)) % FILTER_SIZE);
  localparam int unsigned TILES    = OUT_SIZE / FILTER_SIZE;
  localparam int unsigned AW       = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

  typedef enum logic [1:0] {IDLE, CAPTURE, STREAM, DONE} state_t;

  state_t      state, state_n;
  logic [31:0] buffer [0:OUT_SIZE-1][0:OUT_SIZE-1];
  logic [31:0] tile_n [0:FILTER_SIZE-1][0:FILTER_SIZE-1];
  logic [7:0]  row_n, col_n;
  logic        capture, load, accept, last_n;

  // Next state, next tile indices and datapath strobes
  always_comb begin
    state_n = state;
    row_n   = bus.tile_row;
    col_n   = bus.tile_col;
    capture = 1'b0;
    load    = 1'b0;
    accept  = bus.tile_valid && bus.tile_ready;
    case (state)
      IDLE: begin
        if (bus.en) begin
          state_n = CAPTURE;
          capture = 1'b1;
          row_n   = 8'd0;
          col_n   = 8'd0;
        end
      end
      CAPTURE: begin
        state_n = STREAM;
        load    = 1'b1;
      end
      STREAM: begin
        if (accept) begin
          if (bus.tile_last) begin
            state_n = DONE;
          end else begin
            load = 1'b1;
            if (bus.tile_col == 8'(TILES - 1)) begin
              col_n = 8'd0;
              row_n = bus.tile_row + 8'd1;
            end else begin
              col_n = bus.tile_col + 8'd1;
            end
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    last_n = (row_n == 8'(TILES - 1)) && (col_n == 8'(TILES - 1));
  end

  // Window select of the next tile from the captured buffer
  always_comb begin
    for (int unsigned i = 0; i < FILTER_SIZE; i++) begin
      for (int unsigned j = 0; j < FILTER_SIZE; j++) begin
        tile_n[i][j] = buffer[AW'(32'(row_n) * FILTER_SIZE + i)][AW'(32'(col_n) * FILTER_SIZE + j)];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned r = 0; r < OUT_SIZE; r++) begin
        for (int unsigned c = 0; c < OUT_SIZE; c++) begin
          buffer[r][c] <= 32'd0;
        end
      end
    end else if (capture) begin
      buffer <= bus.array_in;
    end
  end

  // Registered tile outputs; they only move on a load so a stalled tile holds steady
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < FILTER_SIZE; i++) begin
        for (int unsigned j = 0; j < FILTER_SIZE; j++) begin
          bus.tile_out[i][j] <= 32'd0;
        end
      end
      bus.tile_row   <= 8'd0;
      bus.tile_col   <= 8'd0;
      bus.tile_last  <= 1'b0;
      bus.tile_valid <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      bus.tile_row   <= row_n;
      bus.tile_col   <= col_n;
      bus.tile_valid <= (state_n == STREAM);
      bus.busy       <= (state_n == CAPTURE) || (state_n == STREAM);
      bus.done       <= (state_n == DONE);
      if (load) begin
        bus.tile_out  <= tile_n;
        bus.tile_last <= last_n;
      end else if (state_n != STREAM) begin
        bus.tile_last <= 1'b0;
      end
    end
  end

`ifdef TILE_FETCH_SUM_EN
  logic [31:0] sum_n;

  always_comb begin
    sum_n = 32'd0;
    for (int unsigned i = 0; i < FILTER_SIZE; i++) begin
      for (int unsigned j = 0; j < FILTER_SIZE; j++) begin
        sum_n = sum_n + tile_n[i][j];
      end
    end
  end

  // Sum is loaded on the same strobe as tile_out so the two stay aligned
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     bus.tile_sum <= 32'd0;
    else if (load) bus.tile_sum <= sum_n;
  end
`endif

endmodule

// File: tb/tb_tile_fetch.sv
// Scoreboard bench for tile_fetch: 9x9 ramp instance (SIZE=7) and 6x6 constant instance (SIZE=6).
module tb_tile_fetch;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  tile_fetch_if #(.SIZE(7), .FILTER_SIZE(3)) bus7 ();
  tile_fetch_if #(.SIZE(6), .FILTER_SIZE(3)) bus6 ();

  tile_fetch #(.SIZE(7), .FILTER_SIZE(3)) dut7 (.clk(clk), .reset(reset), .bus(bus7));
  tile_fetch #(.SIZE(6), .FILTER_SIZE(3)) dut6 (.clk(clk), .reset(reset), .bus(bus6));

  typedef struct {
    logic [7:0]   row;
    logic [7:0]   col;
    logic         last;
    logic [287:0] data;
    logic [31:0]  sum;
  } exp_t;

  exp_t sb7[$];
  exp_t sb6[$];
  int   errors = 0;
  int   checks = 0;
  int   h00[9] = '{0, 1, 2, 9, 10, 11, 18, 19, 20};
  int   h22[9] = '{60, 61, 62, 69, 70, 71, 78, 79, 80};
  logic last_acc7 = 1'b0;
  logic last_acc6 = 1'b0;

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [287:0] flat7();
    logic [287:0] f;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) f[(i*3+j)*32 +: 32] = bus7.tile_out[i][j];
    return f;
  endfunction

  function automatic logic [287:0] flat6();
    logic [287:0] f;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) f[(i*3+j)*32 +: 32] = bus6.tile_out[i][j];
    return f;
  endfunction

  function automatic exp_t ramp_tile(input int r, input int c);
    exp_t e;
    logic [31:0] v;
    e.row = 8'(r); e.col = 8'(c); e.last = (r == 2 && c == 2); e.sum = 32'd0; e.data = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        v = 32'((r*3 + i)*9 + c*3 + j);
        e.data[(i*3+j)*32 +: 32] = v;
        e.sum += v;
      end
    return e;
  endfunction

  function automatic exp_t hand_tile(input int r, input int c, input int vals[9], input int s);
    exp_t e;
    e.row = 8'(r); e.col = 8'(c); e.last = (r == 2 && c == 2); e.sum = 32'(s); e.data = '0;
    for (int k = 0; k < 9; k++) e.data[k*32 +: 32] = 32'(vals[k]);
    return e;
  endfunction

  task automatic push_ramp();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        if (r == 0 && c == 0)      sb7.push_back(hand_tile(0, 0, h00, 90));
        else if (r == 2 && c == 2) sb7.push_back(hand_tile(2, 2, h22, 630));
        else                       sb7.push_back(ramp_tile(r, c));
      end
  endtask

  task automatic fill7(input logic ramp);
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++) bus7.array_in[r][c] = ramp ? 32'(r*9 + c) : 32'd7;
  endtask

  task automatic pulse_en7();
    @(posedge clk); #1 bus7.en = 1'b1;
    @(posedge clk); #1 bus7.en = 1'b0;
  endtask

  task automatic wait_empty7(input string name);
    int n = 0;
    while (sb7.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    if (sb7.size() != 0) begin
      check({name, "_timeout"}, 320'(sb7.size()), 320'd0);
      sb7.delete();
    end
  endtask

  task automatic check_zero7(input string name);
    check({name, "_tile"}, 320'(flat7()), 320'd0);
    check({name, "_ctl"}, 320'({bus7.tile_valid, bus7.tile_row, bus7.tile_col,
                                bus7.tile_last, bus7.busy, bus7.done}), 320'd0);
  endtask

  // Monitor for the SIZE=7 instance: compares every accepted tile and the done pulse
  always @(negedge clk) begin : mon7
    exp_t e;
    if (reset) begin
      last_acc7 = 1'b0;
    end else begin
      check("done7", 320'(bus7.done), 320'(last_acc7));
      if (last_acc7) check("valid_after_last7", 320'(bus7.tile_valid), 320'd0);
      last_acc7 = 1'b0;
      if (bus7.tile_valid && bus7.tile_ready) begin
        if (sb7.size() == 0) begin
          check("unexpected_tile7", 320'({bus7.tile_row, bus7.tile_col}), 320'hffff);
        end else begin
          e = sb7.pop_front();
          check("idx7", 320'({bus7.tile_row, bus7.tile_col}), 320'({e.row, e.col}));
          check("last7", 320'(bus7.tile_last), 320'(e.last));
          check("data7", 320'(flat7()), 320'(e.data));
`ifdef TILE_FETCH_SUM_EN
          check("sum7", 320'(bus7.tile_sum), 320'(e.sum));
`endif
          last_acc7 = e.last;
        end
      end
    end
  end

  // Monitor for the SIZE=6 instance
  always @(negedge clk) begin : mon6
    exp_t e;
    if (reset) begin
      last_acc6 = 1'b0;
    end else begin
      check("done6", 320'(bus6.done), 320'(last_acc6));
      last_acc6 = 1'b0;
      if (bus6.tile_valid && bus6.tile_ready) begin
        if (sb6.size() == 0) begin
          check("unexpected_tile6", 320'({bus6.tile_row, bus6.tile_col}), 320'hffff);
        end else begin
          e = sb6.pop_front();
          check("idx6", 320'({bus6.tile_row, bus6.tile_col}), 320'({e.row, e.col}));
          check("last6", 320'(bus6.tile_last), 320'(e.last));
          check("data6", 320'(flat6()), 320'(e.data));
`ifdef TILE_FETCH_SUM_EN
          check("sum6", 320'(bus6.tile_sum), 320'(e.sum));
`endif
          last_acc6 = e.last;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cnt;
    int   n;
    exp_t st;

    // Reset with start requested: nothing may capture
    reset = 1'b1;
    bus7.en = 1'b1; bus7.tile_ready = 1'b1; fill7(1'b1);
    bus6.en = 1'b1; bus6.tile_ready = 1'b1;
    for (int r = 0; r < 6; r++) for (int c = 0; c < 6; c++) bus6.array_in[r][c] = 32'd3;
    repeat (3) @(posedge clk);
    #1 check_zero7("reset");
    check("reset6_ctl", 320'({bus6.tile_valid, bus6.busy, bus6.done}), 320'd0);
    bus7.en = 1'b0; bus6.en = 1'b0;
    @(posedge clk); #1 reset = 1'b0;

    // Ramp, ready held high: nine back-to-back tiles
    push_ramp();
    pulse_en7();
    check("capture_busy", 320'({bus7.busy, bus7.tile_valid}), 320'b10);
    @(posedge clk); #1;
    check("first_valid", 320'(bus7.tile_valid), 320'd1);
    cnt = 1;
    for (int k = 0; k < 8; k++) begin @(posedge clk); #1 cnt += int'(bus7.tile_valid); end
    check("throughput", 320'(cnt), 320'd9);
    wait_empty7("run1");
    repeat (3) @(posedge clk);

    // Stall on tile (1,2) while array_in changes and en pulses
    push_ramp();
    pulse_en7();
    n = 0;
    while (!(bus7.tile_valid && bus7.tile_row == 8'd1 && bus7.tile_col == 8'd2) && n < 30) begin
      @(posedge clk); #1; n++;
    end
    check("reach_1_2", 320'(n < 30), 320'd1);
    bus7.tile_ready = 1'b0;
    fill7(1'b0);
    bus7.en = 1'b1;
    st = ramp_tile(1, 2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_data", 320'(flat7()), 320'(st.data));
      check("stall_ctl", 320'({bus7.tile_valid, bus7.tile_row, bus7.tile_col, bus7.busy}),
            320'({1'b1, 8'd1, 8'd2, 1'b1}));
      bus7.en = 1'b0;
    end
    @(posedge clk); #1 bus7.tile_ready = 1'b1;
    wait_empty7("run2");
    repeat (3) @(posedge clk);
    #1 check("no_restart", 320'({bus7.busy, bus7.tile_valid}), 320'd0);

    // Abort with reset after four accepted tiles, then a clean full run
    fill7(1'b1);
    push_ramp();
    pulse_en7();
    n = 0;
    while (sb7.size() != 5 && n < 40) begin @(posedge clk); #1; n++; end
    check("four_accepted", 320'(sb7.size()), 320'd5);
    reset = 1'b1;
    sb7.delete();
    #1 check_zero7("abort");
    @(posedge clk); #1 check_zero7("abort_hold");
    reset = 1'b0;
    push_ramp();
    pulse_en7();
    wait_empty7("run3");
    repeat (3) @(posedge clk);

    // SIZE=6 constant map: four tiles of all 3 (sum 27)
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        st.row = 8'(r); st.col = 8'(c); st.last = (r == 1 && c == 1); st.sum = 32'd27;
        for (int k = 0; k < 9; k++) st.data[k*32 +: 32] = 32'd3;
        sb6.push_back(st);
      end
    @(posedge clk); #1 bus6.en = 1'b1;
    @(posedge clk); #1 bus6.en = 1'b0;
    n = 0;
    while (sb6.size() != 0 && n < 40) begin @(posedge clk); #1; n++; end
    check("run6_drain", 320'(sb6.size()), 320'd0);
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
